imem_program_loader: RTL and testbench

- Writer side of the instruction memory: receives a byte stream (from a UART or debug bridge), assembles little-endian 32-bit instruction words, and drives the instruction memory write port.
- Runs before the core executes. `busy` holds the core/PC in reset while a program is loading.
- Stream format: a 4-byte little-endian word count N, followed by N words of 4 bytes each.

---
 rtl/imem_program_loader.sv | 173 +++++++++++++++++
 tb/tb_imem_program_loader.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_program_loader.sv
// imem_program_loader
// Writer side of the instruction memory. It takes a byte stream from a UART or
// a debug bridge and turns it into instruction memory writes. The stream holds
// a 4-byte little-endian word count N, followed by N little-endian 32-bit words.
// busy holds the core/PC in reset while a program is loading.
//
// Ports:
//   clk        in   system clock, all logic on the rising edge
//   rst        in   synchronous active-high reset
//   start      in   one-cycle pulse; begins a load from IDLE, DONE or ERR
//   in_valid   in   stream byte valid
//   in_data    in   stream byte
//   in_ready   out  loader accepts a byte (transfer on in_valid && in_ready)
//   imem_we    out  instruction memory write enable, one cycle per word
//   imem_addr  out  byte address BASE_ADDR + 4*word_idx
//   imem_wdata out  assembled instruction word
//   busy       out  load in progress (HDR/DATA/WRITE)
//   done       out  last load completed; held until the next accepted start
//   error      out  header count exceeded DEPTH; held until the next accepted start
//
// CNT_W must be at least 32, because the whole 4-byte header is stored.

module imem_program_loader #(
  parameter int          DEPTH     = 41,
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter int          CNT_W     = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  state_t            state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  word_idx_q, word_idx_d;
  logic [31:0]       word_q, word_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              in_ready_q, imem_we_q, busy_q, done_q, error_q;
  logic              accept;

  // Every output is a flop. in_ready comes from the previous edge, so it
  // already describes the state we are in now. That makes it safe to use
  // in_ready here as the handshake qualifier.
  assign accept = in_valid && in_ready_q;

  // This block computes the next state and the datapath updates. The write
  // address and data are latched on the same edge that moves into WRITE. The
  // memory therefore sees stable values for the whole write cycle, and those
  // values stay put afterwards.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    cnt_d      = cnt_q;
    word_idx_d = word_idx_q;
    word_d     = word_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_HDR;
          byte_cnt_d = 2'd0;
          word_idx_d = '0;
          cnt_d      = '0;
        end
      end

      S_HDR: begin
        if (accept) begin
          cnt_d[{byte_cnt_q, 3'b000} +: 8] = in_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if (cnt_d == '0) begin
              state_d = S_DONE;
            end else if (cnt_d > DEPTH_C) begin
              state_d = S_ERR;
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          word_d[{byte_cnt_q, 3'b000} +: 8] = in_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = S_WRITE;
            addr_d  = BASE_ADDR + (32'(word_idx_q) << 2);
            wdata_d = word_d;
          end
        end
      end

      S_WRITE: begin
        word_idx_d = word_idx_q + ONE_C;
        byte_cnt_d = 2'd0;
        state_d    = (word_idx_d == cnt_q) ? S_DONE : S_DATA;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // This block holds the state and datapath registers. The outputs are decoded
  // from the next state, so each one changes on the same edge as the state it
  // describes. rst takes priority over everything else, including start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= 2'd0;
      cnt_q      <= '0;
      word_idx_q <= '0;
      word_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      in_ready_q <= 1'b0;
      imem_we_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      cnt_q      <= cnt_d;
      word_idx_q <= word_idx_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      in_ready_q <= (state_d == S_HDR) || (state_d == S_DATA);
      imem_we_q  <= (state_d == S_WRITE);
      busy_q     <= (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_WRITE);
      done_q     <= (state_d == S_DONE);
      error_q    <= (state_d == S_ERR);
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// tb_imem_program_loader
// This bench drives byte streams into imem_program_loader. The driver pushes
// each expected memory write into a queue as it issues stimulus. A monitor pops
// that queue whenever imem_we is seen and compares the popped entry against the
// write on the port. Status flags are checked directly by the driver.

module tb_imem_program_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        busy;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t expQ[$];

  imem_program_loader #(
    .DEPTH    (41),
    .BASE_ADDR(32'd0),
    .CNT_W    (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  // 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compares one value against its expected value. It counts the comparison
  // and prints a FAIL line when the two differ.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Write monitor. Every write must match the oldest expected entry in the
  // queue. in_ready must be low while a write is in progress.
  always @(negedge clk) begin
    if (!rst && imem_we === 1'b1) begin
      checkOutput("in_ready_during_write", {31'd0, in_ready}, 32'd0);
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write: got addr 0x%08h data 0x%08h, expected no write",
                 imem_addr, imem_wdata);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("write_addr", imem_addr, e.addr);
        checkOutput("write_data", imem_wdata, e.data);
      end
    end
  end

  // Waits for the next negative edge, where outputs are stable for sampling.
  task automatic sampleEdge();
    @(negedge clk);
  endtask

  // Advances one cycle. Inputs then change 1 time unit after the rising edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Presents one byte and holds it until the loader takes it. When gap is set,
  // the task first spends one idle cycle with in_valid low.
  task automatic sendByte(input logic [7:0] b, input bit gap);
    bit acc;
    int waitCycles;
    if (gap) begin
      in_valid = 1'b0;
      stepCycle();
    end
    in_valid   = 1'b1;
    in_data    = b;
    acc        = 1'b0;
    waitCycles = 0;
    while (!acc && waitCycles < 50) begin
      @(negedge clk);
      acc = in_ready;
      stepCycle();
      waitCycles++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("[TB] FAIL byte_accept_timeout: got no transfer of 0x%02h, expected transfer within 50 cycles", b);
    end
  endtask

  // Sends a sequence of bytes in order.
  task automatic applyStimulus(input logic [7:0] bytes[$], input bit gap);
    foreach (bytes[i]) sendByte(bytes[i], gap);
  endtask

  // Issues a one-cycle start pulse.
  task automatic pulseStart();
    start = 1'b1;
    stepCycle();
    start = 1'b0;
  endtask

  // Queues one expected memory write.
  task automatic expectWrite(input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.addr = a;
    e.data = d;
    expQ.push_back(e);
  endtask

  initial begin
    logic [7:0] stim[$];

    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Reset. Other inputs are random while rst is held, and rst must win.
    for (int i = 0; i < 2; i++) begin
      start    = 1'($urandom_range(0, 1));
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom_range(0, 255));
      stepCycle();
    end
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    sampleEdge();
    checkOutput("reset_in_ready",  {31'd0, in_ready}, 32'd0);
    checkOutput("reset_imem_we",   {31'd0, imem_we},  32'd0);
    checkOutput("reset_busy",      {31'd0, busy},     32'd0);
    checkOutput("reset_done",      {31'd0, done},     32'd0);
    checkOutput("reset_error",     {31'd0, error},    32'd0);
    checkOutput("reset_imem_addr", imem_addr,         32'd0);
    checkOutput("reset_imem_wdata", imem_wdata,       32'd0);
    stepCycle();
    rst = 1'b0;
    stepCycle();

    // Two-word load with in_valid held high.
    $display("[TB] two-word load, continuous stream");
    expectWrite(32'h0000_0000, 32'h00C1_0093);
    expectWrite(32'h0000_0004, 32'h0020_8193);
    pulseStart();
    sampleEdge();
    checkOutput("start_busy", {31'd0, busy}, 32'd1);
    stepCycle();
    stim = '{8'h02, 8'h00, 8'h00, 8'h00,
             8'h93, 8'h00, 8'hC1, 8'h00,
             8'h93, 8'h81, 8'h20, 8'h00};
    applyStimulus(stim, 1'b0);
    stepCycle();
    sampleEdge();
    checkOutput("load2_done", {31'd0, done}, 32'd1);
    checkOutput("load2_busy", {31'd0, busy}, 32'd0);
    repeat (4) stepCycle();
    checkOutput("load2_pending", 32'(expQ.size()), 32'd0);

    // A zero count finishes the load immediately and issues no write.
    $display("[TB] zero-count header");
    pulseStart();
    sampleEdge();
    checkOutput("zero_done_cleared", {31'd0, done}, 32'd0);
    stepCycle();
    stim = '{8'h00, 8'h00, 8'h00, 8'h00};
    applyStimulus(stim, 1'b0);
    sampleEdge();
    checkOutput("zero_done",     {31'd0, done},     32'd1);
    checkOutput("zero_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("zero_busy",     {31'd0, busy},     32'd0);

    // A count of 42 exceeds DEPTH of 41, so the load is rejected.
    $display("[TB] oversize header");
    pulseStart();
    stim = '{8'h2A, 8'h00, 8'h00, 8'h00};
    applyStimulus(stim, 1'b0);
    sampleEdge();
    checkOutput("over_error",    {31'd0, error},    32'd1);
    checkOutput("over_busy",     {31'd0, busy},     32'd0);
    checkOutput("over_in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1;
    in_data  = 8'h55;
    for (int i = 0; i < 3; i++) begin
      sampleEdge();
      checkOutput("over_no_consume", {31'd0, in_ready}, 32'd0);
      stepCycle();
    end
    in_valid = 1'b0;
    checkOutput("over_error_held", {31'd0, error}, 32'd1);
    pulseStart();
    sampleEdge();
    checkOutput("over_error_cleared", {31'd0, error}, 32'd0);
    checkOutput("over_restart_busy",  {31'd0, busy},  32'd1);
    stepCycle();
    stim = '{8'h00, 8'h00, 8'h00, 8'h00};
    applyStimulus(stim, 1'b0);
    sampleEdge();
    checkOutput("over_recover_done", {31'd0, done}, 32'd1);

    // Two-word load again, with in_valid toggling and a stray start during DATA.
    $display("[TB] two-word load, toggling valid, start during DATA");
    expectWrite(32'h0000_0000, 32'h00C1_0093);
    expectWrite(32'h0000_0004, 32'h0020_8193);
    pulseStart();
    stim = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h93};
    applyStimulus(stim, 1'b1);
    pulseStart();
    sampleEdge();
    checkOutput("bp_start_ignored_busy", {31'd0, busy}, 32'd1);
    stim = '{8'h00, 8'hC1, 8'h00, 8'h93, 8'h81, 8'h20, 8'h00};
    applyStimulus(stim, 1'b1);
    stepCycle();
    sampleEdge();
    checkOutput("bp_done", {31'd0, done}, 32'd1);
    repeat (3) stepCycle();
    checkOutput("bp_pending", 32'(expQ.size()), 32'd0);

    // Reset in the middle of a word discards it. A fresh load then works.
    $display("[TB] reset mid-word");
    pulseStart();
    stim = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00};
    applyStimulus(stim, 1'b0);
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    sampleEdge();
    checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("midrst_imem_we",  {31'd0, imem_we},  32'd0);
    checkOutput("midrst_busy",     {31'd0, busy},     32'd0);
    checkOutput("midrst_done",     {31'd0, done},     32'd0);
    checkOutput("midrst_error",    {31'd0, error},    32'd0);
    checkOutput("midrst_addr",     imem_addr,         32'd0);
    checkOutput("midrst_wdata",    imem_wdata,        32'd0);
    stepCycle();
    expectWrite(32'h0000_0000, 32'h0000_0013);
    pulseStart();
    stim = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
    applyStimulus(stim, 1'b0);
    stepCycle();
    sampleEdge();
    checkOutput("fresh_done", {31'd0, done}, 32'd1);
    repeat (3) stepCycle();
    checkOutput("final_pending", 32'(expQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Stops the run if the stimulus somehow never completes.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no completion, expected finish before 200000");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] timeout");
  end

endmodule
